// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// master: the block that supplies operands and consumes results.
// slave:  the adder itself.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle adder: {cout,sum} = a + b + cin, DIGIT bits per cycle,
// least significant digit first, carry held in a register between digits.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus,
    output logic          busy
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    if ((WIDTH % DIGIT) != 0 || WIDTH < 1 || DIGIT < 1) begin : g_bad_params
        $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dsum;

    // Sum of the current low digits plus the running carry.
    always_comb begin
        dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    end

    // Control FSM and datapath; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            busy          <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            carry         <= 1'b0;
            cnt           <= '0;
            a_sh          <= '0;
            b_sh          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh         <= bus.a;
                        b_sh         <= bus.b;
                        carry        <= bus.cin;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    carry <= dsum[DIGIT];
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    // New digit enters at the MSB end; written as shift/or so WIDTH==DIGIT stays legal.
                    bus.sum <= (bus.sum >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
                    cnt     <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        bus.cout      <= dsum[DIGIT];
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder in two configurations:
// WIDTH=8/DIGIT=1 and WIDTH=16/DIGIT=4.
module tb_serial_adder;
    logic clk;
    logic rst8;
    logic rst16;
    logic busy8;
    logic busy16;

    int checks;
    int errors;

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk  (clk),
        .rst  (rst8),
        .bus  (if8),
        .busy (busy8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk  (clk),
        .rst  (rst16),
        .bus  (if16),
        .busy (busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation; operands are scrambled right after acceptance.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic [8:0] exp);
        int k;
        check({tag, "_rdy0"}, 32'(if8.in_ready), 32'd1);
        if8.a = ta; if8.b = tb_; if8.cin = tc; if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0; if8.a = ~ta; if8.b = ~tb_; if8.cin = ~tc;
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        check({tag, "_rdy1"}, 32'(if8.in_ready), 32'd0);
        k = 0;
        while (!if8.out_valid && k < 40) begin tick(); k++; end
        check({tag, "_lat"}, 32'(k), 32'd8);
        check({tag, "_res"}, 32'({if8.cout, if8.sum}), 32'(exp));
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        check({tag, "_ovld"}, 32'(if8.out_valid), 32'd0);
        check({tag, "_rdy2"}, 32'(if8.in_ready), 32'd1);
    endtask

    task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic [16:0] exp);
        int k;
        check({tag, "_rdy0"}, 32'(if16.in_ready), 32'd1);
        if16.a = ta; if16.b = tb_; if16.cin = tc; if16.in_valid = 1'b1;
        tick();
        if16.in_valid = 1'b0; if16.a = ~ta; if16.b = ~tb_; if16.cin = ~tc;
        check({tag, "_busy"}, 32'(busy16), 32'd1);
        k = 0;
        while (!if16.out_valid && k < 40) begin tick(); k++; end
        check({tag, "_lat"}, 32'(k), 32'd4);
        check({tag, "_res"}, 32'({if16.cout, if16.sum}), 32'(exp));
        if16.out_ready = 1'b1;
        tick();
        if16.out_ready = 1'b0;
        check({tag, "_rdy2"}, 32'(if16.in_ready), 32'd1);
    endtask

    task automatic rnd8(input int n);
        logic [7:0] ta, tb_;
        logic tc, r;
        int k;
        for (int i = 0; i < n; i++) begin
            ta = 8'($urandom); tb_ = 8'($urandom); tc = 1'($urandom);
            if8.a = ta; if8.b = tb_; if8.cin = tc; if8.in_valid = 1'b1;
            tick();
            if8.in_valid = 1'b0; if8.a = 8'($urandom);
            k = 0;
            while (!if8.out_valid && k < 40) begin tick(); k++; end
            check("rnd8", 32'({if8.cout, if8.sum}), 32'({1'b0, ta} + {1'b0, tb_} + 9'(tc)));
            k = 0;
            do begin
                r = 1'($urandom_range(0, 1));
                if8.out_ready = r;
                tick();
                k++;
            end while (!r && k < 20);
            if8.out_ready = 1'b0;
        end
    endtask

    task automatic rnd16(input int n);
        logic [15:0] ta, tb_;
        logic tc, r;
        int k;
        for (int i = 0; i < n; i++) begin
            ta = 16'($urandom); tb_ = 16'($urandom); tc = 1'($urandom);
            if16.a = ta; if16.b = tb_; if16.cin = tc; if16.in_valid = 1'b1;
            tick();
            if16.in_valid = 1'b0; if16.b = 16'($urandom);
            k = 0;
            while (!if16.out_valid && k < 40) begin tick(); k++; end
            check("rnd16", 32'({if16.cout, if16.sum}), 32'({1'b0, ta} + {1'b0, tb_} + 17'(tc)));
            k = 0;
            do begin
                r = 1'($urandom_range(0, 1));
                if16.out_ready = r;
                tick();
                k++;
            end while (!r && k < 20);
            if16.out_ready = 1'b0;
        end
    endtask

    initial begin
        int k;
        checks = 0;
        errors = 0;
        if8.in_valid = 1'b0;  if8.a = '0;  if8.b = '0;  if8.cin = 1'b0;  if8.out_ready = 1'b0;
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.out_ready = 1'b0;
        rst8 = 1'b1;
        rst16 = 1'b1;
        tick();
        tick();
        rst8 = 1'b0;
        rst16 = 1'b0;

        // Reset state
        check("rst_rdy",   32'(if8.in_ready), 32'd1);
        check("rst_ovld",  32'(if8.out_valid), 32'd0);
        check("rst_busy",  32'(busy8), 32'd0);
        check("rst_sum",   32'({if8.cout, if8.sum}), 32'd0);
        check("rst16_sum", 32'({if16.cout, if16.sum}), 32'd0);
        check("rst16_rdy", 32'(if16.in_ready), 32'd1);

        // Basic and overflow cases
        op8("t1",  8'h01, 8'h01, 1'b0, 9'h002);
        op8("t2a", 8'hFF, 8'h01, 1'b0, 9'h100);
        op8("t2b", 8'h7F, 8'h80, 1'b1, 9'h100);
        op8("t2c", 8'hA5, 8'h3C, 1'b0, 9'h0E1);

        // Backpressure: hold DONE for 5 cycles with in_valid asserted
        if8.a = 8'h0F; if8.b = 8'h0E; if8.cin = 1'b1; if8.in_valid = 1'b1;
        tick();
        if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
        k = 0;
        while (!if8.out_valid && k < 40) begin tick(); k++; end
        check("t3_lat", 32'(k), 32'd8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_res", 32'({if8.cout, if8.sum}), 32'h01E);
            check("t3_hold_vld", 32'(if8.out_valid), 32'd1);
            check("t3_hold_rdy", 32'(if8.in_ready), 32'd0);
        end
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        check("t3_idle_rdy", 32'(if8.in_ready), 32'd1);
        check("t3_idle_vld", 32'(if8.out_valid), 32'd0);
        check("t3_idle_busy", 32'(busy8), 32'd0);
        tick();
        if8.in_valid = 1'b0;
        check("t3_acc_busy", 32'(busy8), 32'd1);
        k = 0;
        while (!if8.out_valid && k < 40) begin tick(); k++; end
        check("t3_lat2", 32'(k), 32'd8);
        check("t3_res2", 32'({if8.cout, if8.sum}), 32'h030);
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;

        // Reset in the third RUN cycle
        if8.a = 8'h12; if8.b = 8'h34; if8.cin = 1'b0; if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        tick();
        tick();
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        check("t4_rdy",  32'(if8.in_ready), 32'd1);
        check("t4_ovld", 32'(if8.out_valid), 32'd0);
        check("t4_busy", 32'(busy8), 32'd0);
        check("t4_sum",  32'({if8.cout, if8.sum}), 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_no_vld", 32'(if8.out_valid), 32'd0);
        end
        op8("t4_op", 8'h55, 8'hAA, 1'b1, 9'h100);

        // 16-bit, 4-bit digits
        op16("t5a", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
        op16("t5b", 16'h1234, 16'h4321, 1'b1, 17'h05556);
        op16("t5c", 16'h8000, 16'h8000, 1'b1, 17'h10001);

        // Random operands with random backpressure
        rnd8(1000);
        rnd16(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
